// File: rtl/char_bbox_locator.sv
// char_bbox_locator: per-frame character bounding-box finder.
// Tracks the min/max x/y of foreground pixels (i_th) inside a fixed search
// window over one frame and, three edges after the frame ends, publishes the
// box bounds plus two horizontal scan rows for the downstream feature scanner.
// Video timing, data and coordinates are passed through with one cycle delay.
//
// Ports:
//   clk, rst_n            pixel clock, asynchronous active-low reset
//   i_hs/i_vs/i_de        video timing (i_vs=1 during the active frame)
//   i_x, i_y, i_data      pixel position and RGB
//   i_th                  binarized foreground flag
//   char_up/down/left/right  latched box bounds
//   row_scanf_line1/2     scan rows for the next frame
//   bbox_valid            last completed frame produced a valid box
//   frame_done            one-cycle pulse when the outputs are refreshed
//   o_hs/o_vs/o_de/o_x/o_y/o_data  one-cycle-delayed copies of the inputs
//
// Optional build macro: BBOX_SMOOTH_EN averages each new bound with the
// previous one when both the previous and the new frame are valid.
module char_bbox_locator #(
  parameter int unsigned WIN_X0     = 0,
  parameter int unsigned WIN_X1     = 479,
  parameter int unsigned WIN_Y0     = 0,
  parameter int unsigned WIN_Y1     = 271,
  parameter int unsigned MIN_PIXELS = 40,
  parameter int unsigned MIN_W      = 4,
  parameter int unsigned MIN_H      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_hs,
  input  logic        i_vs,
  input  logic        i_de,
  input  logic [11:0] i_x,
  input  logic [11:0] i_y,
  input  logic [23:0] i_data,
  input  logic        i_th,
  output logic [11:0] char_up,
  output logic [11:0] char_down,
  output logic [11:0] char_left,
  output logic [11:0] char_right,
  output logic [11:0] row_scanf_line1,
  output logic [11:0] row_scanf_line2,
  output logic        bbox_valid,
  output logic        frame_done,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic [23:0] o_data
);

  localparam int unsigned CW  = 12;
  localparam int unsigned CW1 = CW + 1;
  localparam int unsigned DW  = 24;
  localparam int unsigned HW  = 20;
  localparam int unsigned PW  = 17;

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_ACCUM  = 3'd1,
    S_CALC1  = 3'd2,
    S_CALC2  = 3'd3,
    S_UPDATE = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic            vs_q, vs_d;
  logic [CW-1:0]   min_x_q, min_x_d, max_x_q, max_x_d;
  logic [CW-1:0]   min_y_q, min_y_d, max_y_q, max_y_d;
  logic [HW-1:0]   hits_q, hits_d;
  logic [CW-1:0]   calc_l_q, calc_l_d, calc_r_q, calc_r_d;
  logic [CW-1:0]   calc_u_q, calc_u_d, calc_dn_q, calc_dn_d;
  logic            calc_valid_q, calc_valid_d;
  logic [CW-1:0]   dist_q, dist_d;
  logic [CW-1:0]   char_up_q, char_up_d, char_down_q, char_down_d;
  logic [CW-1:0]   char_left_q, char_left_d, char_right_q, char_right_d;
  logic [CW-1:0]   line1_q, line1_d, line2_q, line2_d;
  logic            bbox_valid_q, bbox_valid_d;
  logic            frame_done_q, frame_done_d;
  logic            o_hs_q, o_hs_d, o_vs_q, o_vs_d, o_de_q, o_de_d;
  logic [CW-1:0]   o_x_q, o_x_d, o_y_q, o_y_d;
  logic [DW-1:0]   o_data_q, o_data_d;

  logic            frame_end_c;
  logic [CW:0]     dx_lo_c, dx_hi_c, dy_lo_c, dy_hi_c;
  logic            hit_c;
  logic [CW-1:0]   width_c, height_c, calc_h_c;
  logic            valid_c;
  logic [PW-1:0]   prod_c;

`ifdef BBOX_SMOOTH_EN
  // Rounded average of old and new bound, 13-bit intermediate sum.
  function automatic logic [CW-1:0] avg_bound(input logic [CW-1:0] a,
                                               input logic [CW-1:0] b);
    logic [CW:0] s;
    s = {1'b0, a} + {1'b0, b} + CW1'(1);
    return s[CW:1];
  endfunction
`endif

  // Frame end: falling edge of i_vs against its registered copy.
  assign frame_end_c = vs_q & ~i_vs;

  // Window test via sign bit of 13-bit differences (no constant compares when a bound is 0).
  assign dx_lo_c = {1'b0, i_x} - CW1'(WIN_X0);
  assign dx_hi_c = CW1'(WIN_X1) - {1'b0, i_x};
  assign dy_lo_c = {1'b0, i_y} - CW1'(WIN_Y0);
  assign dy_hi_c = CW1'(WIN_Y1) - {1'b0, i_y};
  assign hit_c   = i_de & i_th & ~dx_lo_c[CW] & ~dx_hi_c[CW]
                 & ~dy_lo_c[CW] & ~dy_hi_c[CW];

  // Box validity from the accumulators; an empty frame has min>max.
  assign width_c  = max_x_q - min_x_q;
  assign height_c = max_y_q - min_y_q;
  assign valid_c  = (min_x_q <= max_x_q) && (min_y_q <= max_y_q)
                 && (hits_q >= HW'(MIN_PIXELS))
                 && (width_c >= CW'(MIN_W)) && (height_c >= CW'(MIN_H));

  // Scan-line offset: d = (h*21)>>6, roughly h/3.
  assign calc_h_c = calc_dn_q - calc_u_q;
  assign prod_c   = PW'(calc_h_c) * PW'(21);

  // Next-state and datapath.
  always_comb begin
    state_d      = state_q;
    vs_d         = i_vs;
    min_x_d      = min_x_q;
    max_x_d      = max_x_q;
    min_y_d      = min_y_q;
    max_y_d      = max_y_q;
    hits_d       = hits_q;
    calc_l_d     = calc_l_q;
    calc_r_d     = calc_r_q;
    calc_u_d     = calc_u_q;
    calc_dn_d    = calc_dn_q;
    calc_valid_d = calc_valid_q;
    dist_d       = dist_q;
    char_up_d    = char_up_q;
    char_down_d  = char_down_q;
    char_left_d  = char_left_q;
    char_right_d = char_right_q;
    line1_d      = line1_q;
    line2_d      = line2_q;
    bbox_valid_d = bbox_valid_q;
    frame_done_d = 1'b0;
    o_hs_d       = i_hs;
    o_vs_d       = i_vs;
    o_de_d       = i_de;
    o_x_d        = i_x;
    o_y_d        = i_y;
    o_data_d     = i_data;

    case (state_q)
      S_WAIT: begin
        if (i_vs) begin
          min_x_d = '1;
          max_x_d = '0;
          min_y_d = '1;
          max_y_d = '0;
          hits_d  = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (hit_c) begin
          if (i_x < min_x_q) min_x_d = i_x;
          if (i_x > max_x_q) max_x_d = i_x;
          if (i_y < min_y_q) min_y_d = i_y;
          if (i_y > max_y_q) max_y_d = i_y;
          if (hits_q != '1) hits_d = hits_q + HW'(1);
        end
        if (frame_end_c) state_d = S_CALC1;
      end
      S_CALC1: begin
        calc_valid_d = valid_c;
        calc_l_d     = min_x_q;
        calc_r_d     = max_x_q;
        calc_u_d     = min_y_q;
        calc_dn_d    = max_y_q;
`ifdef BBOX_SMOOTH_EN
        if (bbox_valid_q && valid_c) begin
          calc_l_d  = avg_bound(char_left_q,  min_x_q);
          calc_r_d  = avg_bound(char_right_q, max_x_q);
          calc_u_d  = avg_bound(char_up_q,    min_y_q);
          calc_dn_d = avg_bound(char_down_q,  max_y_q);
        end
`endif
        state_d = S_CALC2;
      end
      S_CALC2: begin
        dist_d  = CW'(prod_c >> 6);
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        // Invalid frames keep the previous bounds and scan lines.
        if (calc_valid_q) begin
          char_left_d  = calc_l_q;
          char_right_d = calc_r_q;
          char_up_d    = calc_u_q;
          char_down_d  = calc_dn_q;
          line1_d      = calc_u_q + dist_q;
          line2_d      = calc_dn_q - dist_q;
        end
        bbox_valid_d = calc_valid_q;
        frame_done_d = 1'b1;
        state_d      = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_WAIT;
      vs_q         <= 1'b0;
      min_x_q      <= '1;
      max_x_q      <= '0;
      min_y_q      <= '1;
      max_y_q      <= '0;
      hits_q       <= '0;
      calc_l_q     <= '0;
      calc_r_q     <= '0;
      calc_u_q     <= '0;
      calc_dn_q    <= '0;
      calc_valid_q <= 1'b0;
      dist_q       <= '0;
      char_up_q    <= '0;
      char_down_q  <= '0;
      char_left_q  <= '0;
      char_right_q <= '0;
      line1_q      <= '0;
      line2_q      <= '0;
      bbox_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      o_hs_q       <= 1'b0;
      o_vs_q       <= 1'b0;
      o_de_q       <= 1'b0;
      o_x_q        <= '0;
      o_y_q        <= '0;
      o_data_q     <= '0;
    end else begin
      state_q      <= state_d;
      vs_q         <= vs_d;
      min_x_q      <= min_x_d;
      max_x_q      <= max_x_d;
      min_y_q      <= min_y_d;
      max_y_q      <= max_y_d;
      hits_q       <= hits_d;
      calc_l_q     <= calc_l_d;
      calc_r_q     <= calc_r_d;
      calc_u_q     <= calc_u_d;
      calc_dn_q    <= calc_dn_d;
      calc_valid_q <= calc_valid_d;
      dist_q       <= dist_d;
      char_up_q    <= char_up_d;
      char_down_q  <= char_down_d;
      char_left_q  <= char_left_d;
      char_right_q <= char_right_d;
      line1_q      <= line1_d;
      line2_q      <= line2_d;
      bbox_valid_q <= bbox_valid_d;
      frame_done_q <= frame_done_d;
      o_hs_q       <= o_hs_d;
      o_vs_q       <= o_vs_d;
      o_de_q       <= o_de_d;
      o_x_q        <= o_x_d;
      o_y_q        <= o_y_d;
      o_data_q     <= o_data_d;
    end
  end

  assign char_up         = char_up_q;
  assign char_down       = char_down_q;
  assign char_left       = char_left_q;
  assign char_right      = char_right_q;
  assign row_scanf_line1 = line1_q;
  assign row_scanf_line2 = line2_q;
  assign bbox_valid      = bbox_valid_q;
  assign frame_done      = frame_done_q;
  assign o_hs            = o_hs_q;
  assign o_vs            = o_vs_q;
  assign o_de            = o_de_q;
  assign o_x             = o_x_q;
  assign o_y             = o_y_q;
  assign o_data          = o_data_q;

endmodule
